// File: rtl/melody_sequencer_if.sv
// Control, melody-RAM write and playback signals of melody_sequencer.
// The loop input exists only when MELODY_LOOP_EN is defined.
interface melody_sequencer_if #(
    parameter int CODE_W = 4,
    parameter int DUR_W  = 2,
    parameter int DEPTH  = 64
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                      beat;
    logic                      start;
    logic                      stop;
    logic                      pause;
    logic [ADDR_W-1:0]         last_addr;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DUR_W+CODE_W-1:0]   wr_data;
`ifdef MELODY_LOOP_EN
    logic                      loop;
`endif
    logic [CODE_W-1:0]         tune_code;
    logic                      tune_valid;
    logic                      busy;
    logic                      done;
    logic [ADDR_W-1:0]         play_addr;

    modport master (
`ifdef MELODY_LOOP_EN
        output loop,
`endif
        output beat, start, stop, pause, last_addr, wr_en, wr_addr, wr_data,
        input  tune_code, tune_valid, busy, done, play_addr
    );

    modport slave (
`ifdef MELODY_LOOP_EN
        input  loop,
`endif
        input  beat, start, stop, pause, last_addr, wr_en, wr_addr, wr_data,
        output tune_code, tune_valid, busy, done, play_addr
    );
endinterface

// File: rtl/melody_sequencer.sv
// Beat-driven melody player over a {dur, code} RAM; rest code is all-ones.
// Define MELODY_LOOP_EN to add the loop input (wrap to entry 0 instead of ending).
module melody_sequencer #(
    parameter int CODE_W = 4,
    parameter int DUR_W  = 2,
    parameter int DEPTH  = 64
) (
    input  logic               clk,
    input  logic               rst,
    melody_sequencer_if.slave  bus
);
    localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRY_W = DUR_W + CODE_W;
    localparam logic [ADDR_W-1:0] LAST_MAX = ADDR_W'(DEPTH - 1);
    localparam logic [CODE_W-1:0] REST     = '1;

    typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

    state_t              state, state_nx;
    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]   play_addr, last_q, next_addr, fetch_addr, last_clamped;
    logic [ENTRY_W-1:0]  fetch_data;
    logic [DUR_W-1:0]    cnt;
    logic [CODE_W-1:0]   tune_code_q;
    logic                tune_valid_q, done_q;
    logic                loop_en, beat_ev, note_end, melody_end;

`ifdef MELODY_LOOP_EN
    assign loop_en = bus.loop;
`else
    assign loop_en = 1'b0;
`endif

    // Beats only count in PLAY when no higher-priority control is asserted.
    always_comb begin
        beat_ev      = (state == PLAY) && !bus.stop && !bus.start && !bus.pause && bus.beat;
        note_end     = beat_ev && (cnt == '0);
        melody_end   = note_end && (play_addr == last_q);
        next_addr    = play_addr + ADDR_W'(1);
        last_clamped = (int'(bus.last_addr) > DEPTH - 1) ? LAST_MAX : bus.last_addr;
        fetch_addr   = (bus.start || melody_end) ? '0 : next_addr;
        fetch_data   = mem[fetch_addr];
    end

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // NOTE: default assignment first, so no path leaves state_nx unassigned (no latch).
    always_comb begin
        state_nx = state;
        if (bus.stop)
            state_nx = IDLE;
        else if (bus.start)
            state_nx = PLAY;
        else begin
            case (state)
                PLAY:    if (bus.pause)                  state_nx = PAUSE;
                         else if (melody_end && !loop_en) state_nx = IDLE;
                PAUSE:   if (!bus.pause)                 state_nx = PLAY;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy = (state != IDLE);
    end

    assign bus.tune_code  = tune_code_q;
    assign bus.tune_valid = tune_valid_q;
    assign bus.done       = done_q;
    assign bus.play_addr  = play_addr;

    // Read is combinational into registered outputs, so a fetched entry is
    // visible the cycle after start or the advancing beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            play_addr    <= '0;
            last_q       <= '0;
            cnt          <= '0;
            tune_code_q  <= '0;
            tune_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                tune_valid_q <= 1'b0;
            end else if (bus.start) begin
                last_q       <= last_clamped;
                play_addr    <= '0;
                tune_code_q  <= fetch_data[CODE_W-1:0];
                tune_valid_q <= (fetch_data[CODE_W-1:0] != REST);
                cnt          <= fetch_data[ENTRY_W-1:CODE_W];
            end else if (note_end) begin
                if (melody_end && !loop_en) begin
                    tune_valid_q <= 1'b0;
                    done_q       <= 1'b1;
                end else begin
                    play_addr    <= fetch_addr;
                    tune_code_q  <= fetch_data[CODE_W-1:0];
                    tune_valid_q <= (fetch_data[CODE_W-1:0] != REST);
                    cnt          <= fetch_data[ENTRY_W-1:CODE_W];
                end
            end else if (beat_ev) begin
                cnt <= cnt - DUR_W'(1);
            end
        end
    end

    // NOTE: the melody RAM is deliberately not reset; its contents are only
    // meaningful once written, and a reset would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (int'(bus.wr_addr) < DEPTH))
            mem[bus.wr_addr] <= bus.wr_data;
    end
endmodule

// File: tb/tb_melody_sequencer.sv
// Directed scoreboard bench for melody_sequencer: expected outputs are queued
// with each stimulus step and compared one cycle later.
module tb_melody_sequencer;
    localparam int CODE_W = 4;
    localparam int DUR_W  = 2;
    localparam int DEPTH  = 64;

    typedef struct {
        logic [3:0] code;
        logic       valid;
        logic [5:0] addr;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    melody_sequencer_if #(.CODE_W(CODE_W), .DUR_W(DUR_W), .DEPTH(DEPTH)) bif ();

    melody_sequencer #(.CODE_W(CODE_W), .DUR_W(DUR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic v, input logic [5:0] a,
                        input logic b, input logic d);
        exp_t e;
        e.code = c; e.valid = v; e.addr = a; e.busy = b; e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=no_entry expected=queued_entry", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".code"},  32'(bif.tune_code),  32'(e.code));
        check({tag, ".valid"}, 32'(bif.tune_valid), 32'(e.valid));
        check({tag, ".addr"},  32'(bif.play_addr),  32'(e.addr));
        check({tag, ".busy"},  32'(bif.busy),       32'(e.busy));
        check({tag, ".done"},  32'(bif.done),       32'(e.done));
    endtask

    // One clock with the currently driven inputs; pulses drop after the edge.
    task automatic step(input string tag, input logic [3:0] c, input logic v,
                        input logic [5:0] a, input logic b, input logic d);
        push(c, v, a, b, d);
        @(posedge clk);
        #1;
        bif.beat  = 1'b0;
        bif.start = 1'b0;
        bif.stop  = 1'b0;
        bif.wr_en = 1'b0;
        compare_out(tag);
    endtask

    // Beat followed by three quiet cycles, giving one beat every 4 clocks.
    task automatic beat_step(input string tag, input logic [3:0] c, input logic v,
                             input logic [5:0] a);
        bif.beat = 1'b1;
        step(tag, c, v, a, 1'b1, 1'b0);
        repeat (3) step({tag, "_gap"}, c, v, a, 1'b1, 1'b0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [1:0] d, input logic [3:0] c);
        bif.wr_en   = 1'b1;
        bif.wr_addr = a;
        bif.wr_data = {d, c};
        @(posedge clk);
        #1;
        bif.wr_en = 1'b0;
    endtask

    initial begin
        bif.beat = 1'b0; bif.start = 1'b0; bif.stop = 1'b0; bif.pause = 1'b0;
        bif.last_addr = '0; bif.wr_en = 1'b0; bif.wr_addr = '0; bif.wr_data = '0;
`ifdef MELODY_LOOP_EN
        bif.loop = 1'b0;
`endif
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        push(0, 0, 0, 0, 0);
        compare_out("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // Basic three-note melody, one beat every 4 clocks.
        wr(0, 0, 3); wr(1, 1, 5); wr(2, 0, 7);
        bif.last_addr = 2; bif.start = 1'b1;
        step("t1_start", 3, 1, 0, 1, 0);
        beat_step("t1_b1", 5, 1, 1);
        beat_step("t1_b2", 5, 1, 1);
        beat_step("t1_b3", 7, 1, 2);
        bif.beat = 1'b1;
        step("t1_end", 7, 0, 2, 0, 1);
        step("t1_idle", 7, 0, 2, 0, 0);

        // Rest entry lasts 4 beats with tune_valid low.
        wr(0, 3, 15); wr(1, 0, 2);
        bif.last_addr = 1; bif.start = 1'b1;
        step("t2_start", 15, 0, 0, 1, 0);
        beat_step("t2_r1", 15, 0, 0);
        beat_step("t2_r2", 15, 0, 0);
        beat_step("t2_r3", 15, 0, 0);
        beat_step("t2_adv", 2, 1, 1);
        bif.beat = 1'b1;
        step("t2_end", 2, 0, 1, 0, 1);
        step("t2_idle", 2, 0, 1, 0, 0);

        // Pause for 10 clocks spanning 2 beats mid-note.
        wr(0, 3, 4); wr(1, 0, 6);
        bif.start = 1'b1;
        step("t3_start", 4, 1, 0, 1, 0);
        beat_step("t3_b1", 4, 1, 0);
        bif.pause = 1'b1;
        repeat (2) step("t3_pause", 4, 1, 0, 1, 0);
        bif.beat = 1'b1;
        step("t3_pbeat1", 4, 1, 0, 1, 0);
        repeat (3) step("t3_pause", 4, 1, 0, 1, 0);
        bif.beat = 1'b1;
        step("t3_pbeat2", 4, 1, 0, 1, 0);
        repeat (3) step("t3_pause", 4, 1, 0, 1, 0);
        bif.pause = 1'b0;
        step("t3_resume", 4, 1, 0, 1, 0);
        beat_step("t3_b2", 4, 1, 0);
        beat_step("t3_b3", 4, 1, 0);
        beat_step("t3_adv", 6, 1, 1);
        bif.beat = 1'b1;
        step("t3_end", 6, 0, 1, 0, 1);

        // Restart while busy, then stop and start together.
        bif.start = 1'b1;
        step("t4_start", 4, 1, 0, 1, 0);
        repeat (3) begin
            bif.beat = 1'b1;
            step("t4_beat", 4, 1, 0, 1, 0);
        end
        bif.beat = 1'b1;
        step("t4_adv", 6, 1, 1, 1, 0);
        bif.start = 1'b1;
        step("t4_restart", 4, 1, 0, 1, 0);
        bif.beat = 1'b1;
        step("t4_beat2", 4, 1, 0, 1, 0);
        bif.stop = 1'b1; bif.start = 1'b1;
        step("t4_stop_start", 4, 0, 0, 0, 0);
        step("t4_idle", 4, 0, 0, 0, 0);

        // Write to the entry being fetched in the same cycle returns old data.
        wr(0, 0, 9); wr(1, 0, 10);
        bif.start = 1'b1;
        step("t5_start", 9, 1, 0, 1, 0);
        bif.beat = 1'b1;
        bif.wr_en = 1'b1; bif.wr_addr = 1; bif.wr_data = {2'd0, 4'd11};
        step("t5_collide", 10, 1, 1, 1, 0);
        bif.beat = 1'b1;
        step("t5_end", 10, 0, 1, 0, 1);
        bif.start = 1'b1;
        step("t5_restart", 9, 1, 0, 1, 0);
        bif.beat = 1'b1;
        step("t5_newdata", 11, 1, 1, 1, 0);
        bif.stop = 1'b1;
        step("t5_stop", 11, 0, 1, 0, 0);

        // Single-entry melody (last_addr = 0).
        bif.last_addr = 0; bif.start = 1'b1;
        step("t6_start", 9, 1, 0, 1, 0);
        bif.beat = 1'b1;
        step("t6_end", 9, 0, 0, 0, 1);
        step("t6_idle", 9, 0, 0, 0, 0);

        // Asynchronous reset during entry 1, then replay from entry 0.
        wr(1, 1, 10);
        bif.last_addr = 1; bif.start = 1'b1;
        step("t7_start", 9, 1, 0, 1, 0);
        bif.beat = 1'b1;
        step("t7_e1", 10, 1, 1, 1, 0);
        #2 rst = 1'b0;
        #1;
        push(0, 0, 0, 0, 0);
        compare_out("t7_rst_async");
        @(posedge clk);
        #1;
        push(0, 0, 0, 0, 0);
        compare_out("t7_rst_held");
        rst = 1'b1;
        bif.start = 1'b1;
        step("t7_restart", 9, 1, 0, 1, 0);
        bif.stop = 1'b1;
        step("t7_stop", 9, 0, 0, 0, 0);

`ifdef MELODY_LOOP_EN
        // Looping melody wraps 0,1,2,0,1 with no done pulse.
        wr(0, 0, 1); wr(1, 0, 2); wr(2, 0, 3);
        bif.last_addr = 2; bif.loop = 1'b1; bif.start = 1'b1;
        step("t8_start", 1, 1, 0, 1, 0);
        bif.beat = 1'b1; step("t8_a1", 2, 1, 1, 1, 0);
        bif.beat = 1'b1; step("t8_a2", 3, 1, 2, 1, 0);
        bif.beat = 1'b1; step("t8_wrap", 1, 1, 0, 1, 0);
        bif.beat = 1'b1; step("t8_a1b", 2, 1, 1, 1, 0);
        bif.loop = 1'b0; bif.stop = 1'b1;
        step("t8_stop", 2, 0, 1, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter CODE_W, default 4, width of tune code (code 0 = low G ... 8 = high C; all-ones = rest).
REQ-002 SHALL have parameter DUR_W, default 2, per-note duration field width; note lasts dur+1 beats.
REQ-003 SHALL have parameter DEPTH, default 64, melody RAM entries; ADDR_W = clog2(DEPTH).
REQ-004 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: beat  in  1  one-cycle tempo tick.
REQ-007 SHALL have ports: start  in  1; stop  in  1; pause  in  1 (level, hold while high).
REQ-008 SHALL have ports: last_addr  in  ADDR_W  index of final melody entry, sampled on start.
REQ-009 SHALL have ports: wr_en  in  1; wr_addr  in  ADDR_W; wr_data  in  DUR_W+CODE_W  as {dur, code}.
REQ-010 SHALL have ports: tune_code  out  CODE_W; tune_valid  out  1 (high when playing a non-rest code); busy  out  1; done  out  1 (one-cycle pulse); play_addr  out  ADDR_W.

Function
REQ-011 SHALL implement states IDLE, PLAY, PAUSE; busy = 1 in PLAY and PAUSE.
REQ-012 IDLE + start: SHALL latch last_addr, set play_addr = 0, enter PLAY; entry 0 appears on tune_code/tune_valid exactly 1 cycle after start.
REQ-013 In PLAY each beat SHALL decrement remaining-beat counter; beat with counter = 0 SHALL advance play_addr and present the next entry 1 cycle later with counter = its dur.
REQ-014 Beat ending entry at latched last_addr, loop = 0: SHALL pulse done 1 cycle, return IDLE, tune_valid = 0, tune_code holds last code.
REQ-015 Same event with loop = 1: SHALL wrap play_addr to 0 without gap, no done pulse.
REQ-016 pause high in PLAY SHALL enter PAUSE next cycle; beats ignored, outputs frozen; pause low returns PLAY, counter resumes unchanged.
REQ-017 stop in PLAY/PAUSE SHALL return IDLE next cycle, tune_valid = 0, no done pulse.
REQ-018 Priority SHALL be stop > start > pause > beat; start while busy restarts from entry 0.
REQ-019 Code all-ones SHALL count beats normally with tune_valid = 0.
REQ-020 Writes SHALL be accepted in any state; same-cycle read/write of one address returns old data; written entry used when next fetched.
REQ-021 last_addr >= DEPTH SHALL be clamped to DEPTH-1.
REQ-022 Counter and address arithmetic SHALL be unsigned, wrap-free within declared widths.

Reset
REQ-023 rst low SHALL immediately force IDLE, tune_code = 0, tune_valid = 0, busy = 0, done = 0, play_addr = 0, counter = 0; RAM contents undefined.
REQ-024 Reset mid-melody SHALL abandon playback; first start after release plays from entry 0.

Configuration
REQ-025 Macro MELODY_LOOP_EN defined: input port loop (1 bit) SHALL exist, behaviour per REQ-015.
REQ-026 Macro undefined: loop port SHALL be absent and treated as 0; every melody end pulses done.

Verification
REQ-027 Load {0,3},{1,5},{0,7}, last_addr=2, start, beat every 4 clk -> codes 3,5,5,7 one per beat, done one cycle after 4th beat, then IDLE.
REQ-028 Entry {3,15} (rest) -> tune_valid 0 for 4 beats, tune_code 15, address then advances.
REQ-029 MELODY_LOOP_EN, loop=1, 3-entry melody -> play_addr 0,1,2,0,1 continuous, no done pulse.
REQ-030 pause high 10 clk across 2 beats mid-note -> outputs frozen, note finishes with original remaining beats.
REQ-031 stop and start same cycle while playing -> stop wins, IDLE, done stays 0.
REQ-032 rst low during entry 1 -> all outputs 0 immediately; start after release -> entry 0 after 1 cycle.
